// File: rtl/conv_layer_seq.sv
// Layer sequencer for the conv/pool datapath: loads the 3x3 kernel, then for each
// output row refills the line buffer from source memory and hands off to the convolve engine.
module conv_layer_seq #(
  parameter int BIT_DEPTH = 8,
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int KSIZE     = 3,
  parameter int ADDR_W    = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           stride,
  input  logic [ADDR_W-1:0]    img_base,
  input  logic [ADDR_W-1:0]    kern_base,
  output logic                 src_rd_en,
  output logic [ADDR_W-1:0]    src_addr,
  input  logic [BIT_DEPTH-1:0] src_rd_data,
  output logic                 kern_wr_en,
  output logic [3:0]           kern_addr,
  output logic [BIT_DEPTH-1:0] kern_data,
  output logic                 lb_wr_en,
  output logic [BIT_DEPTH-1:0] lb_r1,
  output logic [BIT_DEPTH-1:0] lb_r2,
  output logic [BIT_DEPTH-1:0] lb_r3,
  output logic                 conv_start,
  output logic [1:0]           conv_stride,
  input  logic                 conv_done,
  output logic [4:0]           out_row,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           dbg_state
);

  localparam int KN     = KSIZE * KSIZE;
  localparam int FILL_N = 3 * IMG_W;
  localparam int CNT_W  = $clog2(((FILL_N > KN) ? FILL_N : KN) + 1);
  localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W + 1) : 1;
  localparam int ROW_W  = $clog2(IMG_H + 4);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_K = 3'd1,
    S_FILL   = 3'd2,
    S_CONV   = 3'd3,
    S_WAIT   = 3'd4,
    S_NEXT   = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t                state, state_nxt;
  logic [1:0]            stride_q;
  logic [ADDR_W-1:0]     img_base_q;
  logic [ADDR_W-1:0]     kern_base_q;
  logic [CNT_W-1:0]      cnt;
  logic [COL_W-1:0]      col;
  logic [1:0]            sub;
  logic [ROW_W-1:0]      r;
  logic [ROW_W-1:0]      r_step;
  logic                  ret_vld;
  logic [1:0]            ret_sub;
  logic [BIT_DEPTH-1:0]  stage1;
  logic [BIT_DEPTH-1:0]  stage2;
  logic [ADDR_W-1:0]     fill_addr;
  logic                  fill_issue;
  logic                  fits_next;

  assign r_step     = r + ROW_W'(stride_q);
  assign fits_next  = (int'(r_step) + KSIZE) <= IMG_H;
  assign fill_issue = (state == S_FILL) && (cnt < CNT_W'(FILL_N));
  assign fill_addr  = img_base_q + ADDR_W'((int'(r) + int'(sub)) * IMG_W + int'(col));

  assign dbg_state   = state;
  assign conv_stride = stride_q;
  assign out_row     = 5'((stride_q == 2'd2) ? (r >> 1) : r);
  assign busy        = (state != S_IDLE) && (state != S_DONE);

  always_comb begin
    state_nxt  = state;
    src_rd_en  = 1'b0;
    src_addr   = '0;
    kern_wr_en = 1'b0;
    kern_addr  = '0;
    kern_data  = '0;
    lb_wr_en   = 1'b0;
    lb_r1      = '0;
    lb_r2      = '0;
    lb_r3      = '0;
    conv_start = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LOAD_K;
      end
      S_LOAD_K: begin
        if (cnt < CNT_W'(KN)) begin
          src_rd_en = 1'b1;
          src_addr  = kern_base_q + ADDR_W'(cnt);
        end
        // Each weight lands one cycle after its read, so write index trails the counter.
        if (cnt != '0) begin
          kern_wr_en = 1'b1;
          kern_addr  = 4'(cnt - CNT_W'(1));
          kern_data  = src_rd_data;
        end
        if (cnt == CNT_W'(KN)) state_nxt = S_FILL;
      end
      S_FILL: begin
        if (fill_issue) begin
          src_rd_en = 1'b1;
          src_addr  = fill_addr;
        end
        if (ret_vld && ret_sub == 2'd2) begin
          lb_wr_en = 1'b1;
          lb_r1    = stage1;
          lb_r2    = stage2;
          lb_r3    = src_rd_data;
        end
        if (cnt == CNT_W'(FILL_N)) state_nxt = S_CONV;
      end
      S_CONV: begin
        conv_start = 1'b1;
        state_nxt  = S_WAIT;
      end
      S_WAIT: begin
        if (conv_done) state_nxt = S_NEXT;
      end
      S_NEXT: begin
        state_nxt = fits_next ? S_FILL : S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      stride_q    <= '0;
      img_base_q  <= '0;
      kern_base_q <= '0;
      cnt         <= '0;
      col         <= '0;
      sub         <= '0;
      r           <= '0;
      ret_vld     <= 1'b0;
      ret_sub     <= '0;
      stage1      <= '0;
      stage2      <= '0;
    end else begin
      state   <= state_nxt;
      ret_vld <= fill_issue;
      ret_sub <= sub;
      if (ret_vld && ret_sub == 2'd0) stage1 <= src_rd_data;
      if (ret_vld && ret_sub == 2'd1) stage2 <= src_rd_data;
      case (state)
        S_IDLE: begin
          if (start) begin
            // Anything but a stride of 2 runs as stride 1.
            stride_q    <= (stride == 2'd2) ? 2'd2 : 2'd1;
            img_base_q  <= img_base;
            kern_base_q <= kern_base;
            cnt         <= '0;
            r           <= '0;
          end
        end
        S_LOAD_K: begin
          if (cnt == CNT_W'(KN)) begin
            cnt <= '0;
            col <= '0;
            sub <= '0;
            r   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_FILL: begin
          if (fill_issue) begin
            cnt <= cnt + CNT_W'(1);
            if (sub == 2'd2) begin
              sub <= '0;
              col <= col + COL_W'(1);
            end else begin
              sub <= sub + 2'd1;
            end
          end else begin
            cnt <= '0;
          end
        end
        S_NEXT: begin
          r   <= r_step;
          cnt <= '0;
          col <= '0;
          sub <= '0;
        end
        S_DONE: begin
          r <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_layer_seq.sv
// Bench for conv_layer_seq: random source memory, responsive convolve-engine model,
// and a row/column reference model that predicts kernel, line-buffer and conv traffic.
module tb_conv_layer_seq;

  localparam int W  = 28;
  localparam int H  = 28;
  localparam int KS = 3;
  localparam int KN = KS * KS;
  localparam int AW = 10;

  logic          clk;
  logic          rst;
  logic          start;
  logic [1:0]    stride;
  logic [AW-1:0] img_base;
  logic [AW-1:0] kern_base;
  logic          src_rd_en;
  logic [AW-1:0] src_addr;
  logic [7:0]    src_rd_data;
  logic          kern_wr_en;
  logic [3:0]    kern_addr;
  logic [7:0]    kern_data;
  logic          lb_wr_en;
  logic [7:0]    lb_r1, lb_r2, lb_r3;
  logic          conv_start;
  logic [1:0]    conv_stride;
  logic          conv_done;
  logic [4:0]    out_row;
  logic          busy;
  logic          done;
  logic [2:0]    dbg_state;

  logic          done_m, done_x;
  assign conv_done = done_m | done_x;

  conv_layer_seq dut (
    .clk(clk), .rst(rst), .start(start), .stride(stride),
    .img_base(img_base), .kern_base(kern_base),
    .src_rd_en(src_rd_en), .src_addr(src_addr), .src_rd_data(src_rd_data),
    .kern_wr_en(kern_wr_en), .kern_addr(kern_addr), .kern_data(kern_data),
    .lb_wr_en(lb_wr_en), .lb_r1(lb_r1), .lb_r2(lb_r2), .lb_r3(lb_r3),
    .conv_start(conv_start), .conv_stride(conv_stride), .conv_done(conv_done),
    .out_row(out_row), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // Clock and source memory model (1-cycle read latency)
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:(1<<AW)-1];
  initial src_rd_data = '0;
  always @(posedge clk) if (src_rd_en) src_rd_data <= mem[src_addr];

  // Convolve engine model: done pulse conv_lat cycles after each conv_start
  int conv_lat = 5;
  initial begin
    done_m = 1'b0;
    forever begin
      @(negedge clk);
      if (conv_start && !rst) begin
        repeat (conv_lat) @(negedge clk);
        done_m = 1'b1;
        @(negedge clk);
        done_m = 1'b0;
      end
    end
  end

  // Scoreboard state
  int checks = 0;
  int errors = 0;
  logic [11:0] exp_k_q[$], obs_k_q[$];
  logic [23:0] exp_lb_q[$], obs_lb_q[$];
  logic [4:0]  exp_row_q[$], obs_row_q[$];
  logic [1:0]  exp_stride;
  int cyc = 0, rd_idx, t_rd0, t_rd8, t_rd9, last_lb, done_cnt;
  int bad_addr, bad_stride, bad_gap, bad_busy;

  // Monitor samples 1 time unit after the active edge
  always @(posedge clk) begin
    #1;
    cyc++;
    if (!rst) begin
      if (src_rd_en) begin
        if (rd_idx == 0)  t_rd0 = cyc;
        if (rd_idx == KN - 1) t_rd8 = cyc;
        if (rd_idx == KN) t_rd9 = cyc;
        rd_idx++;
      end else if (src_addr != '0) bad_addr++;
      if (kern_wr_en) obs_k_q.push_back({kern_addr, kern_data});
      if (lb_wr_en) begin
        obs_lb_q.push_back({lb_r1, lb_r2, lb_r3});
        last_lb = cyc;
      end
      if (conv_start) begin
        obs_row_q.push_back(out_row);
        if (conv_stride != exp_stride) bad_stride++;
        if (last_lb != cyc - 1) bad_gap++;
      end
      if (done) begin
        done_cnt++;
        if (busy) bad_busy++;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {src_rd_en, src_addr, kern_wr_en, kern_addr, kern_data, lb_wr_en,
            lb_r1, lb_r2, lb_r3, conv_start, conv_stride, out_row, busy, done, dbg_state};
  endfunction

  // Reference model: rows r = 0, s, 2s, ... while the 3-row window fits in the image
  task automatic build_expected(input logic [1:0] s_in, input logic [AW-1:0] ib,
                                input logic [AW-1:0] kb);
    int s;
    logic [AW-1:0] a0, a1, a2;
    s = (s_in == 2'd2) ? 2 : 1;
    exp_stride = 2'(s);
    exp_k_q.delete(); exp_lb_q.delete(); exp_row_q.delete();
    for (int k = 0; k < KN; k++) begin
      a0 = kb + AW'(k);
      exp_k_q.push_back({4'(k), mem[a0]});
    end
    for (int row = 0; row + KS <= H; row += s) begin
      exp_row_q.push_back(5'(row / s));
      for (int c = 0; c < W; c++) begin
        a0 = ib + AW'(row * W + c);
        a1 = ib + AW'((row + 1) * W + c);
        a2 = ib + AW'((row + 2) * W + c);
        exp_lb_q.push_back({mem[a0], mem[a1], mem[a2]});
      end
    end
  endtask

  task automatic clear_obs();
    obs_k_q.delete(); obs_lb_q.delete(); obs_row_q.delete();
    rd_idx = 0; t_rd0 = 0; t_rd8 = 0; t_rd9 = 0; last_lb = -10; done_cnt = 0;
    bad_addr = 0; bad_stride = 0; bad_gap = 0; bad_busy = 0;
  endtask

  // Driver: one full layer, optionally with a stray conv_done and an ignored second start
  task automatic run_layer(input string name, input logic [1:0] s_in,
                           input logic [AW-1:0] ib, input logic [AW-1:0] kb, input bit extras);
    bit got;
    clear_obs();
    build_expected(s_in, ib, kb);
    start = 1'b1; stride = s_in; img_base = ib; kern_base = kb;
    if (extras) done_x = 1'b1;
    @(negedge clk);
    start = 1'b0; done_x = 1'b0;
    stride = 2'($urandom); img_base = AW'($urandom); kern_base = AW'($urandom);
    check({name, "_busy_after_start"}, busy, 1);
    if (extras) begin
      repeat (3) @(negedge clk);
      done_x = 1'b1;
      @(negedge clk);
      done_x = 1'b0;
      repeat (25) @(negedge clk);
      start = 1'b1; stride = 2'd1;
      @(negedge clk);
      start = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
    end
    check({name, "_done_seen"}, got, 1);
    check({name, "_busy_low_at_done"}, busy, 0);
    check({name, "_kern_count"}, obs_k_q.size(), exp_k_q.size());
    for (int i = 0; i < exp_k_q.size() && i < obs_k_q.size(); i++)
      check({name, "_kern_write"}, obs_k_q[i], exp_k_q[i]);
    check({name, "_lb_count"}, obs_lb_q.size(), exp_lb_q.size());
    for (int i = 0; i < exp_lb_q.size() && i < obs_lb_q.size(); i++)
      check({name, "_lb_column"}, obs_lb_q[i], exp_lb_q[i]);
    check({name, "_conv_count"}, obs_row_q.size(), exp_row_q.size());
    for (int i = 0; i < exp_row_q.size() && i < obs_row_q.size(); i++)
      check({name, "_out_row"}, obs_row_q[i], exp_row_q[i]);
    check({name, "_read_count"}, rd_idx, KN + exp_row_q.size() * 3 * W);
    check({name, "_kern_read_span"}, t_rd8 - t_rd0, KN - 1);
    check({name, "_fill_start_delay"}, t_rd9 - t_rd0, KN + 1);
    check({name, "_addr_zero_when_idle"}, bad_addr, 0);
    check({name, "_conv_stride"}, bad_stride, 0);
    check({name, "_conv_after_last_lb"}, bad_gap, 0);
    check({name, "_done_with_busy"}, bad_busy, 0);
    check({name, "_done_pulses"}, done_cnt, 1);
    @(negedge clk);
    check({name, "_idle_after_done"}, {busy, done}, 2'b00);
  endtask

  // Main directed sequence
  initial begin
    bit got;
    rst = 1'b1; start = 1'b0; stride = '0; img_base = '0; kern_base = '0; done_x = 1'b0;
    for (int a = 0; a < (1 << AW); a++) mem[a] = 8'($urandom);
    clear_obs();
    exp_stride = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_outputs_zero", all_outs(), 64'd0);
    end

    for (int k = 0; k < KN; k++) mem[10'h100 + k] = 8'(k + 1);
    run_layer("kern_s1", 2'd1, 10'd0, 10'h100, 1'b0);

    conv_lat = 5;
    run_layer("s2_base0", 2'd2, 10'd0, AW'($urandom), 1'b0);
    conv_lat = $urandom_range(1, 6);
    run_layer("s3_as_s1", 2'd3, AW'($urandom), AW'($urandom), 1'b0);
    conv_lat = $urandom_range(1, 6);
    run_layer("s0_b2b", 2'd0, AW'($urandom), AW'($urandom), 1'b0);
    run_layer("wrap_s2", 2'd2, 10'h3F0, 10'h3FC, 1'b0);
    conv_lat = $urandom_range(2, 6);
    run_layer("extras_s2", 2'd2, AW'($urandom), AW'($urandom), 1'b1);

    // Reset two cycles into WAIT
    conv_lat = 5;
    start = 1'b1; stride = 2'd1; img_base = AW'($urandom); kern_base = AW'($urandom);
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (conv_start) begin got = 1'b1; break; end
    end
    check("rst_conv_start_seen", got, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_outputs_zero", all_outs(), 64'd0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("rst_no_done", done, 0);
    conv_lat = $urandom_range(1, 6);
    run_layer("after_rst", 2'd1, AW'($urandom), AW'($urandom), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_layer_seq.md
Name: conv_layer_seq

Overview:
- Layer-level sequencer for the conv/pool datapath (convolve engine, 3-row line buffer, 3x3 kernel register).
- On a start pulse it loads the 9 kernel weights from source memory into the kernel register.
- For each output row it refills the line buffer with three image rows, triggers the convolve engine and waits for its done, then advances by the stride until the image is exhausted.
- Sits between the NPU top-level control and the single-port source memory.

Parameters:
- BIT_DEPTH, 8, data word width
- IMG_W, 28, image columns (line buffer depth)
- IMG_H, 28, image rows
- KSIZE, 3, kernel edge; kernel holds KSIZE*KSIZE words
- ADDR_W, 10, source memory address width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a layer
- stride  in  2  row/col stride (1 or 2); latched at start
- img_base  in  ADDR_W  image base address; latched at start
- kern_base  in  ADDR_W  kernel base address; latched at start
- src_rd_en  out  1  source memory read strobe
- src_addr  out  ADDR_W  source memory read address
- src_rd_data  in  BIT_DEPTH  read data, valid 1 cycle after src_rd_en
- kern_wr_en  out  1  kernel register write
- kern_addr  out  4  kernel register index 0..8
- kern_data  out  BIT_DEPTH  kernel write data
- lb_wr_en  out  1  line buffer column write
- lb_r1, lb_r2, lb_r3  out  BIT_DEPTH each  column data for rows r, r+1, r+2
- conv_start  out  1  one-cycle pulse to convolve engine
- conv_stride  out  2  latched stride to convolve engine
- conv_done  in  1  convolve engine done pulse
- out_row  out  5  current output row index, drives convolve in_dest_addr
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at layer end

Behaviour:
- Reset: state IDLE; every output is 0; internal row/col/kernel counters are 0.
- Start acceptance: start is accepted only in IDLE. When accepted, stride, img_base and kern_base are latched. A latched stride other than 1 or 2 is treated as 1.
- States: IDLE, LOAD_K, FILL, CONV, WAIT, NEXT, DONE.
- IDLE -> LOAD_K on an accepted start.
- LOAD_K:
  - Issues reads at kern_base+k for k=0..8 on consecutive cycles.
  - One cycle after each read: kern_wr_en=1, kern_addr=k, kern_data=src_rd_data.
  - Takes 10 cycles, then goes to FILL with r=0.
- FILL:
  - For each column c=0..IMG_W-1, issues 3 back-to-back reads at img_base+(r+i)*IMG_W+c, i=0,1,2. Reads are pipelined, with no bubbles between columns.
  - Data for row r is staged to lb_r1 and row r+1 to lb_r2.
  - On the cycle the third read returns: lb_wr_en=1, lb_r3=src_rd_data.
  - Duration is 3*IMG_W+1 cycles. The last lb_wr_en coincides with the transition to CONV.
- CONV: conv_start=1 for exactly 1 cycle, out_row=r/stride_latched, then WAIT.
- WAIT:
  - Holds until conv_done=1.
  - conv_done outside WAIT is ignored.
  - No timeout.
- NEXT: r <= r+stride. If (r+stride)+KSIZE <= IMG_H go to FILL, else go to DONE.
- DONE: done=1 for 1 cycle, busy=0, then IDLE.
- Address arithmetic: computed at ADDR_W bits; wrap-around is silent.
- src_rd_en is high only on read-issue cycles. src_addr is 0 when src_rd_en=0.
- Simultaneous start and conv_done in IDLE: start accepted, conv_done ignored.
- Reset asserted mid-operation: returns to IDLE next edge, all strobes deasserted, no done pulse.
- Throughput: a start can be accepted the cycle after done.

Test Plan:
- Reset then idle with no start -> every output stays 0, busy=0, done=0 for 20 cycles.
- Kernel memory words 1..9 at kern_base=0x100, start -> kern_wr_en for exactly 9 cycles; kern_addr 0..8 carries kern_data 1..9; FILL begins 10 cycles after start accept.
- IMG_W=4, IMG_H=5, stride=1, src[a]=a[7:0], img_base=0:
  - row 0 fill gives lb columns (0,4,8),(1,5,9),(2,6,10),(3,7,11);
  - 3 conv_start pulses with out_row=0,1,2;
  - done after the third conv_done.
- IMG defaults, stride=2, conv_done returned 5 cycles after each conv_start -> 13 conv_start pulses with out_row 0..12; src row bases 0,56,...,672; a single done pulse.
- stride=3 latched -> behaves as stride 1: 26 conv_start pulses.
- Reset 2 cycles into WAIT -> the next cycle all outputs are 0 and state is IDLE. A following start runs a full layer correctly. A second start during busy is ignored (conv_start count unchanged).
